// File: rtl/multicycle_cpu_if.sv
// Instruction-memory bus of multicycle_cpu: req/ack fetch handshake.
// master = core side, slave = memory side.
interface multicycle_cpu_if #(
  parameter int PC_W = 8
);
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic [15:0]     imem_rdata;
  logic            imem_ack;

  modport master (output imem_req, imem_addr, input imem_rdata, imem_ack);
  modport slave  (input imem_req, imem_addr, output imem_rdata, imem_ack);
endinterface

// File: rtl/multicycle_cpu.sv
// multicycle_cpu: 16-bit-instruction multi-cycle core.
// FETCH -> DECODE -> EXEC -> WB per instruction, HALT is terminal until reset.
// Optional feature: define MULTICYCLE_CPU_R0_ZERO_EN to hard-wire r0 to zero
// (writes to r0 still pulse wb_valid but are not stored).
module multicycle_cpu #(
  parameter int DW     = 16,
  parameter int PC_W   = 8,
  parameter int RST_PC = 0
) (
  input  logic             clk,
  input  logic             rst,
  multicycle_cpu_if.master imem,
  output logic             wb_valid,
  output logic [2:0]       wb_addr,
  output logic [DW-1:0]    wb_data,
  output logic [PC_W-1:0]  pc_out,
  output logic             halted
);

  localparam int SH_W = $clog2(DW);

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT} state_e;

  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_SHL  = 4'h6;
  localparam logic [3:0] OP_SHR  = 4'h7;
  localparam logic [3:0] OP_LDI  = 4'h8;
  localparam logic [3:0] OP_BEQZ = 4'h9;
  localparam logic [3:0] OP_JMP  = 4'hA;
  localparam logic [3:0] OP_HALT = 4'hF;

  state_e          r_state, w_next;
  logic            r_started;
  logic [PC_W-1:0] r_pc, w_pc_next, w_imm_pc;
  logic [15:0]     r_ir;
  logic [DW-1:0]   r_regs [8];
  logic [DW-1:0]   r_a, r_b, r_result, w_alu, w_imm_dw, w_rf_a, w_rf_b;
  logic            r_take;
  logic            w_req, w_wr_en, w_reg_we;
  logic [3:0]      w_op;
  logic [2:0]      w_rd, w_rs1, w_rs2, w_ra_sel;
  logic [11:0]     w_imm12;
  logic            w_unused_imm;

  assign w_op     = r_ir[15:12];
  assign w_rd     = r_ir[11:9];
  assign w_rs1    = r_ir[8:6];
  assign w_rs2    = r_ir[5:3];
  assign w_imm12  = r_ir[11:0];
  assign w_imm_dw = {{(DW-9){r_ir[8]}}, r_ir[8:0]};
  assign w_imm_pc = PC_W'({{3{r_ir[8]}}, r_ir[8:0]});
  assign w_unused_imm = ^w_imm12;

  // BEQZ tests rd, so the A read port switches to rd for that opcode.
  assign w_ra_sel = (w_op == OP_BEQZ) ? w_rd : w_rs1;
  // Opcodes 1..8 are exactly the register-writing ones.
  assign w_wr_en  = (w_op >= OP_ADD) && (w_op <= OP_LDI);

`ifdef MULTICYCLE_CPU_R0_ZERO_EN
  assign w_rf_a   = (w_ra_sel == 3'd0) ? '0 : r_regs[w_ra_sel];
  assign w_rf_b   = (w_rs2 == 3'd0) ? '0 : r_regs[w_rs2];
  assign w_reg_we = w_wr_en && (w_rd != 3'd0);
`else
  assign w_rf_a   = r_regs[w_ra_sel];
  assign w_rf_b   = r_regs[w_rs2];
  assign w_reg_we = w_wr_en;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) r_state <= S_FETCH;
    else     r_state <= w_next;
  end

  // Next-state and fetch request; the first request waits one cycle after reset.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    w_next = r_state;
    w_req  = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_req = r_started;
        if (w_req && imem.imem_ack) w_next = S_DECODE;
      end
      S_DECODE: w_next = S_EXEC;
      S_EXEC:   w_next = (w_op == OP_HALT) ? S_HALT : S_WB;
      S_WB:     w_next = S_FETCH;
      S_HALT:   w_next = S_HALT;
      default:  w_next = S_FETCH;
    endcase
  end

  // ALU; shift amounts use only the low log2(DW) bits of B.
  always_comb begin
    w_alu = '0;
    case (w_op)
      OP_ADD:  w_alu = r_a + r_b;
      OP_SUB:  w_alu = r_a - r_b;
      OP_AND:  w_alu = r_a & r_b;
      OP_OR:   w_alu = r_a | r_b;
      OP_XOR:  w_alu = r_a ^ r_b;
      OP_SHL:  w_alu = r_a << r_b[SH_W-1:0];
      OP_SHR:  w_alu = r_a >> r_b[SH_W-1:0];
      OP_LDI:  w_alu = w_imm_dw;
      default: w_alu = '0;
    endcase
  end

  // Next PC, wrapping modulo 2^PC_W.
  always_comb begin
    w_pc_next = r_pc + PC_W'(1);
    if (w_op == OP_BEQZ && r_take) w_pc_next = r_pc + w_imm_pc;
    else if (w_op == OP_JMP)       w_pc_next = w_imm12[PC_W-1:0];
  end

  // Datapath registers: instruction, operands, result, register file, PC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_started <= 1'b0;
      r_pc      <= PC_W'(RST_PC);
      r_ir      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_result  <= '0;
      r_take    <= 1'b0;
      // NOTE: the 8-entry register file must read as zero after reset, so it
      // is built from resettable flops rather than an inferred RAM.
      for (int i = 0; i < 8; i++) r_regs[i] <= '0;
    end else begin
      r_started <= 1'b1;
      case (r_state)
        S_FETCH:  if (w_req && imem.imem_ack) r_ir <= imem.imem_rdata;
        S_DECODE: begin
          r_a <= w_rf_a;
          r_b <= w_rf_b;
        end
        S_EXEC: begin
          r_result <= w_alu;
          r_take   <= (r_a == '0);
        end
        S_WB: begin
          if (w_reg_we) r_regs[w_rd] <= r_result;
          r_pc <= w_pc_next;
        end
        default: ;
      endcase
    end
  end

  assign imem.imem_req  = w_req;
  assign imem.imem_addr = r_pc;
  assign wb_valid       = (r_state == S_WB) && w_wr_en;
  assign wb_addr        = w_rd;
  assign wb_data        = r_result;
  assign pc_out         = r_pc;
  assign halted         = (r_state == S_HALT);

endmodule
